// File: rtl/uart_tx_if.sv
// Byte handshake and serial-line bundle between an upstream byte source and uart_tx.
// master = byte source, slave = transmitter.
interface uart_tx_if;
   logic       tx_valid;
   logic [7:0] d_in;
   logic       tx_ready;
   logic       tx;
   logic       tx_busy;
   logic       tx_done;

   modport master (output tx_valid, output d_in,
                   input  tx_ready, input tx, input tx_busy, input tx_done);
   modport slave  (input  tx_valid, input d_in,
                   output tx_ready, output tx, output tx_busy, output tx_done);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity bit, 1 stop bit.
// Parity bit is present only when UART_TX_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | line high, ready for a byte
// START  | driving start bit (0)
// DATA   | driving shift[0], 8 bits LSB first
// PARITY | driving parity of latched byte (UART_TX_PARITY_EN only)
// STOP   | driving stop bit (1); tx_done pulses as it ends
module uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 5208,
   parameter int unsigned PARITY_ODD   = 0
) (
   input logic     clk,
   input logic     reset,
   uart_tx_if.slave bus
);

   localparam logic [15:0] CNT_MAX = 16'(CLKS_PER_BIT - 1);

   // Reject out-of-range configurations at elaboration time.
   if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || PARITY_ODD > 1) begin : g_bad_param
      $error("uart_tx: CLKS_PER_BIT must be 2..65535 and PARITY_ODD 0 or 1");
   end

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t      state;
   logic [15:0] bit_cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shift;
   logic        tx_r;
   logic        ready_r;
   logic        busy_r;
   logic        done_r;
`ifdef UART_TX_PARITY_EN
   logic        par_bit;
`endif

   logic bit_end;
   assign bit_end = (bit_cnt == CNT_MAX);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         bit_cnt <= '0;
         bit_idx <= '0;
         shift   <= '0;
         tx_r    <= 1'b1;
         ready_r <= 1'b1;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_bit <= 1'b0;
`endif
      end else begin
         done_r <= 1'b0;
         if (state != IDLE)
            bit_cnt <= bit_end ? 16'd0 : bit_cnt + 16'd1;

         case (state)
            IDLE: begin
               if (bus.tx_valid) begin
                  shift   <= bus.d_in;
`ifdef UART_TX_PARITY_EN
                  par_bit <= (^bus.d_in) ^ (PARITY_ODD != 0);
`endif
                  bit_cnt <= '0;
                  state   <= START;
                  tx_r    <= 1'b0;
                  ready_r <= 1'b0;
                  busy_r  <= 1'b1;
               end
            end
            START: begin
               if (bit_end) begin
                  state   <= DATA;
                  bit_idx <= '0;
                  tx_r    <= shift[0];
               end
            end
            DATA: begin
               if (bit_end) begin
                  shift   <= shift >> 1;
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     state <= PARITY;
                     tx_r  <= par_bit;
`else
                     state <= STOP;
                     tx_r  <= 1'b1;
`endif
                  end else begin
                     tx_r <= shift[1];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  state <= STOP;
                  tx_r  <= 1'b1;
               end
            end
`endif
            STOP: begin
               if (bit_end) begin
                  state   <= IDLE;
                  done_r  <= 1'b1;
                  ready_r <= 1'b1;
                  busy_r  <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               tx_r    <= 1'b1;
               ready_r <= 1'b1;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.tx       = tx_r;
   assign bus.tx_ready = ready_r;
   assign bus.tx_busy  = busy_r;
   assign bus.tx_done  = done_r;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter, the transmit-side counterpart of the existing receive path.
- Accepts one byte per valid/ready handshake and serialises it on tx. Frame order: start bit (0), 8 data bits LSB first, optional parity bit, 1 stop bit (1).
- Bit timing comes from an internal per-bit clock counter, so each frame is timed independently of any free-running baud tick.
- Sits beside the receive top-level and drives the board UART TX pin.

Parameters:
- CLKS_PER_BIT, 5208, clk cycles per serial bit (50 MHz / 9600 baud). Legal range 2..65535.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity. Used only when the parity feature is compiled in.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- tx_valid  input  1  d_in holds a byte to send.
- d_in  input  8  byte to transmit.
- tx_ready  output  1  transmitter idle; a byte is accepted on any edge with tx_valid=1 and tx_ready=1.
- tx  output  1  serial line, idles high.
- tx_busy  output  1  frame in progress; always the inverse of tx_ready.
- tx_done  output  1  one-cycle pulse at the end of the stop bit.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, tx=1, tx_ready=1, tx_busy=0, tx_done=0.
  - Bit counter, bit index and shift register all cleared.
  - Reset asserted mid-frame aborts the frame; tx goes high immediately, with no partial stop bit.
- State machine: IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE.
- IDLE:
  - tx=1, tx_ready=1.
  - On an edge with tx_valid=1, d_in is latched into the shift register, the parity bit is computed from d_in, the bit counter is cleared, and the state goes to START.
  - tx_ready falls and tx goes 0 on that same edge (latency: 1 clk from the accepting edge to the start of the start bit).
- Bit timing:
  - Bit counter runs 0..CLKS_PER_BIT-1.
  - When it reaches CLKS_PER_BIT-1 it wraps to 0 and the current bit ends.
  - Every bit, including the start bit, lasts exactly CLKS_PER_BIT cycles.
- START: tx=0 for one bit time, then go to DATA with bit index=0.
- DATA:
  - tx = shift register bit 0.
  - At each bit end: shift right, bit index +1.
  - After index 7 ends, go to PARITY if compiled in, otherwise to STOP.
- PARITY: tx = (XOR of the latched byte) XOR PARITY_ODD, for one bit time.
- STOP:
  - tx=1 for one bit time.
  - At bit end: tx_done=1 for exactly one cycle and the state goes to IDLE with tx_ready=1.
- Back-to-back frames:
  - With tx_valid held high, the next byte is accepted on the first IDLE cycle.
  - tx is therefore high for CLKS_PER_BIT+1 cycles between frames (the stop bit plus one idle clk).
- tx_valid or d_in changes while tx_busy=1 are ignored. The latched byte is immune to d_in changes.
- tx is driven directly from a register, so it is glitch-free.
- No FIFO; upstream must hold tx_valid until it sees tx_ready.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: the PARITY state is included. The frame is 11 bits = 11*CLKS_PER_BIT cycles, matching the receiver's parity check.
- Undefined: the PARITY state and parity logic are removed; DATA goes straight to STOP. The frame is 10 bits = 10*CLKS_PER_BIT cycles. PARITY_ODD is unused.

Test Plan:
- Use CLKS_PER_BIT=16 for all tests; sample tx at mid-bit.
- Single byte, parity compiled in, even parity: reset, then tx_valid pulse with d_in=0xA5.
  - tx sequence = 0,1,0,1,0,0,1,0,1,0(parity),1(stop), each bit 16 clk.
  - tx_ready low for 176 clk.
  - tx_done pulses once, 176 clk after the accepting edge.
- Parity variants with d_in=0x07:
  - Even parity bit = 1.
  - PARITY_ODD=1 gives parity bit = 0.
  - With UART_TX_PARITY_EN undefined: no parity bit, frame is 160 clk, and the bit after data bit 7 is the stop bit (1).
- Back-to-back: tx_valid held high with 0x55 then 0xAA.
  - Two complete frames.
  - Inter-frame high time is exactly 17 clk (stop bit + 1 idle).
  - Exactly two tx_done pulses.
- Busy protection: during the 0x3C frame, pulse tx_valid with d_in=0xFF at clk 40.
  - Transmitted data is still 0x3C.
  - No second frame is sent.
  - tx_ready stays 0 until the stop bit ends.
- Reset mid-frame: assert reset=0 during data bit 3 of a 0x00 frame.
  - tx=1 immediately (asynchronous); tx_ready=1, tx_done=0.
  - After release, a new 0x81 frame transmits correctly from its start bit.
- Loopback: tx connected to the existing receiver with matched baud.
  - For bytes 0x00, 0xFF, 0x5A, 0xC3, the received d_out equals the sent byte.
  - p_error=0 and stop_error=0 throughout.
